sisc_ctrl_mc: RTL
=================

Name: sisc_ctrl_mc

Overview:
- Parametrised multi-cycle control FSM for the SISC datapath.
- Supersedes the fixed single-pass controller. Adds a memory request/acknowledge handshake with wait states, used for instruction fetch and for data LOD/STR.
- Adds a bus timeout and a proper HALT state in place of simulation stop.
- Drives rf, alu, mux, ir, pc and memory control lines from present state, opcode, mm, stat and mem_ack.

Parameters:
- OP_W, 4, opcode field width.
- CC_W, 4, width of mm condition mask and of stat; branch logic spans all CC_W bits.
- IMM_MODE, 8, mm value selecting the immediate operand for ALU ops.
- TIMEOUT, 15, maximum wait cycles for mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  system clock, posedge active
- rst_f  in  1  asynchronous active-low reset
- opcode  in  OP_W  instr opcode field
- mm  in  CC_W  instr mode / condition mask
- stat  in  CC_W  status register output
- mem_ack  in  1  memory completes the request this cycle
- rf_we  out  1  register file write enable
- alu_op  out  2  bit1 = do not save status; bit0 = use immediate
- wb_sel  out  1  0 = alu_result, 1 = memory read data
- br_sel  out  1  1 = absolute branch target, 0 = relative
- rb_sel  out  1  1 = read RD on the RB port (store data)
- ir_load  out  1  IR captures memory data
- pc_sel  out  1  1 = branch target, 0 = PC+1
- pc_write  out  1  PC update enable
- pc_rst  out  1  PC reset
- mem_req  out  1  memory access request
- mem_we  out  1  memory write; valid with mem_req
- mm_sel  out  1  0 = PC drives the address, 1 = alu_result drives it
- halted  out  1  FSM in HALT
- bus_err  out  1  HALT was entered by timeout

Behaviour:
- Reset:
  - rst_f low asynchronously forces state START0 and clears wait_cnt and the bus_err flop.
  - Outputs are decoded combinationally from state, so on reset every output is 0 except pc_rst=1 and alu_op=2'b10.
- Defaults in every state: all outputs 0, alu_op=2'b10, unless listed below.
- State sequence: START0 -> START1 -> FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK -> FETCH. HALT is terminal until reset.
- START0, START1: pc_rst=1.
- FETCH:
  - mem_req=1, mm_sel=0, mem_we=0.
  - Hold in FETCH while mem_ack=0.
  - In the ack cycle: ir_load=1, pc_write=1, pc_sel=0; next state DECODE.
- DECODE:
  - HLT (opcode all ones) -> HALT.
  - Branch opcodes: BRA=4, BNE=6 set br_sel=1; BRR=5, BNR=7 set br_sel=0.
  - hit = |(mm & stat).
  - Taken when mm==0 (unconditional), or hit for BRA/BRR, or !hit for BNE/BNR.
  - Taken: pc_sel=1, pc_write=1, one cycle.
- EXECUTE:
  - ALU_OP=8: alu_op={0, mm==IMM_MODE}.
  - LOD=1 and STR=2: alu_op=2'b11 (address = RB + imm, status not saved).
  - STR: rb_sel=1.
- MEM:
  - ALU_OP: alu_op={1, mm==IMM_MODE}.
  - LOD: mem_req=1, mm_sel=1, alu_op=2'b11. Hold until mem_ack.
  - STR: the same, plus mem_we=1 and rb_sel=1.
  - Other opcodes pass through MEM in one cycle with no request.
- WRITEBACK:
  - ALU_OP: rf_we=1, wb_sel=0.
  - LOD: rf_we=1, wb_sel=1, alu_op=2'b11.
- NOOP and SWP=3 (reserved): traverse all states with no side effects.
- Wait counter:
  - wait_cnt has width clog2(TIMEOUT+1). It clears on entry to FETCH or MEM.
  - It increments each cycle mem_req=1 and mem_ack=0.
  - If TIMEOUT>0 and wait_cnt==TIMEOUT with mem_ack=0: next state HALT, bus_err flop set.
- Boundary rules:
  - mem_ack in the timeout cycle: ack wins, no error.
  - mem_ack while mem_req=0: ignored.
  - Opcode and stat are sampled only in DECODE and are not latched by this block.
- HALT: halted=1, all other outputs at defaults, mem_req=0. bus_err is held until reset.
- Reset mid-access: mem_req drops asynchronously and the next FETCH restarts from START0.

Test Plan:
- Reset, then ADD (opcode 8, mm 0) with mem_ack tied 1 -> 7 cycles from START0 to WRITEBACK; rf_we=1 for exactly one cycle; alu_op 00 in EXECUTE, 10 in MEM.
- Fetch with mem_ack delayed 3 cycles -> mem_req high 4 cycles; ir_load and pc_write high only in the ack cycle.
- Branches with stat=4'b0010:
  - BRA mm=0010 -> pc_sel=1, pc_write=1, br_sel=1 in DECODE.
  - BNR mm=0010 -> no pc_write.
  - BNR mm=0100 -> taken with br_sel=0.
  - BRR mm=0000 -> taken.
- LOD with 2 wait states -> MEM holds 3 cycles with mm_sel=1 and mem_we=0; WRITEBACK has rf_we=1, wb_sel=1.
- STR -> MEM has mem_we=1, rb_sel=1; no rf_we.
- mem_ack held low with TIMEOUT=15 -> HALT after 16 request cycles with bus_err=1; an ack arriving in cycle 16 instead -> no error. HLT opcode -> halted=1, bus_err=0. rst_f low in HALT -> START0 with pc_rst=1.

Source files
------------

// File: rtl/sisc_ctrl_mc.sv
// sisc_ctrl_mc: multi-cycle control FSM for the SISC datapath.
//
// The state sequence is START0 -> START1 -> FETCH -> DECODE -> EXECUTE -> MEM
// -> WRITEBACK -> FETCH. HALT is terminal until reset.
// Instruction fetch and data LOD/STR use a request/acknowledge handshake with
// wait states. A bounded wait counter sends the FSM to HALT with bus_err set
// when the memory fails to acknowledge in time.
//
// Ports:
//   clk      - system clock, posedge active
//   rst_f    - asynchronous active-low reset
//   opcode   - instruction opcode field (sampled, not latched)
//   mm       - instruction mode / condition mask
//   stat     - status register output
//   mem_ack  - memory completes the outstanding request this cycle
//   rf_we    - register file write enable
//   alu_op   - bit1 = do not save status, bit0 = use immediate
//   wb_sel   - 0 = alu_result, 1 = memory read data
//   br_sel   - 1 = absolute branch target, 0 = relative
//   rb_sel   - 1 = read RD on the RB port (store data)
//   ir_load  - IR captures memory data
//   pc_sel   - 1 = branch target, 0 = PC+1
//   pc_write - PC update enable
//   pc_rst   - PC reset
//   mem_req  - memory access request
//   mem_we   - memory write, qualified by mem_req
//   mm_sel   - 0 = PC drives the address, 1 = alu_result drives it
//   halted   - FSM is in HALT
//   bus_err  - HALT was entered through a memory timeout
module sisc_ctrl_mc #(
  parameter int OP_W     = 4,
  parameter int CC_W     = 4,
  parameter int IMM_MODE = 8,
  parameter int TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic [OP_W-1:0] opcode,
  input  logic [CC_W-1:0] mm,
  input  logic [CC_W-1:0] stat,
  input  logic            mem_ack,
  output logic            rf_we,
  output logic [1:0]      alu_op,
  output logic            wb_sel,
  output logic            br_sel,
  output logic            rb_sel,
  output logic            ir_load,
  output logic            pc_sel,
  output logic            pc_write,
  output logic            pc_rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mm_sel,
  output logic            halted,
  output logic            bus_err
);

  localparam logic [2:0] S_START0    = 3'd0;
  localparam logic [2:0] S_START1    = 3'd1;
  localparam logic [2:0] S_FETCH     = 3'd2;
  localparam logic [2:0] S_DECODE    = 3'd3;
  localparam logic [2:0] S_EXECUTE   = 3'd4;
  localparam logic [2:0] S_MEM       = 3'd5;
  localparam logic [2:0] S_WRITEBACK = 3'd6;
  localparam logic [2:0] S_HALT      = 3'd7;

  // A zero TIMEOUT still needs a 1-bit counter to keep the logic legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             bus_err_reg;
  logic             set_err;

  // Opcode decode
  logic is_lod, is_str, is_alu, is_hlt, is_br, br_abs, br_inv;
  logic use_imm, hit, taken, timeout;

  assign is_lod  = (opcode == OP_W'(1));
  assign is_str  = (opcode == OP_W'(2));
  assign is_alu  = (opcode == OP_W'(8));
  assign is_hlt  = (opcode == '1);
  assign is_br   = (opcode == OP_W'(4)) || (opcode == OP_W'(5)) ||
                   (opcode == OP_W'(6)) || (opcode == OP_W'(7));
  assign br_abs  = (opcode == OP_W'(4)) || (opcode == OP_W'(6));
  // BNE/BNR branch on the absence of a condition hit.
  assign br_inv  = (opcode == OP_W'(6)) || (opcode == OP_W'(7));
  assign use_imm = (mm == CC_W'(IMM_MODE));
  assign hit     = |(mm & stat);
  assign taken   = (mm == '0) || (hit ^ br_inv);
  // An ack in the last allowed cycle wins over the timeout.
  assign timeout = (TIMEOUT > 0) && (wait_cnt_reg == CNT_W'(TIMEOUT)) && !mem_ack;

  always_comb begin
    rf_we      = 1'b0;
    alu_op     = 2'b10;
    wb_sel     = 1'b0;
    br_sel     = 1'b0;
    rb_sel     = 1'b0;
    ir_load    = 1'b0;
    pc_sel     = 1'b0;
    pc_write   = 1'b0;
    pc_rst     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mm_sel     = 1'b0;
    halted     = 1'b0;
    set_err    = 1'b0;
    state_next = state_reg;
    case (state_reg)
      S_START0: begin
        pc_rst     = 1'b1;
        state_next = S_START1;
      end
      S_START1: begin
        pc_rst     = 1'b1;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load    = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          set_err    = 1'b1;
          state_next = S_HALT;
        end
      end
      S_DECODE: begin
        if (is_hlt) begin
          state_next = S_HALT;
        end else begin
          state_next = S_EXECUTE;
          if (is_br) begin
            br_sel = br_abs;
            if (taken) begin
              pc_sel   = 1'b1;
              pc_write = 1'b1;
            end
          end
        end
      end
      S_EXECUTE: begin
        state_next = S_MEM;
        if (is_alu) begin
          alu_op = {1'b0, use_imm};
        end else if (is_lod || is_str) begin
          alu_op = 2'b11;
          rb_sel = is_str;
        end
      end
      S_MEM: begin
        state_next = S_WRITEBACK;
        if (is_alu) begin
          alu_op = {1'b1, use_imm};
        end else if (is_lod || is_str) begin
          alu_op  = 2'b11;
          mem_req = 1'b1;
          mm_sel  = 1'b1;
          mem_we  = is_str;
          rb_sel  = is_str;
          if (mem_ack) begin
            state_next = S_WRITEBACK;
          end else if (timeout) begin
            set_err    = 1'b1;
            state_next = S_HALT;
          end else begin
            state_next = S_MEM;
          end
        end
      end
      S_WRITEBACK: begin
        state_next = S_FETCH;
        if (is_alu) begin
          rf_we = 1'b1;
        end else if (is_lod) begin
          rf_we  = 1'b1;
          wb_sel = 1'b1;
          alu_op = 2'b11;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = S_START0;
      end
    endcase
  end

  // Any state change restarts the count, so every FETCH/MEM entry sees zero.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (state_next != state_reg) begin
      wait_cnt_next = '0;
    end else if (mem_req && !mem_ack) begin
      wait_cnt_next = wait_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_reg    <= S_START0;
      wait_cnt_reg <= '0;
      bus_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (set_err) begin
        bus_err_reg <= 1'b1;
      end
    end
  end

  assign bus_err = bus_err_reg;

endmodule
